// File: rtl/iob_dbus_split_pkg.sv
// Shared state encoding, error read data and watchdog limit for the IOb data-bus splitter.
package iob_dbus_split_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT_RD = 2'd1,
    ST_ERR_RD  = 2'd2
  } state_e;

  // Wide enough for any practical DATA_W; users slice the low DATA_W bits.
  localparam logic [255:0] ERR_RDATA = '1;

  function automatic int unsigned TOUT_MAX(input int unsigned tout_w);
    return (32'd1 << tout_w) - 32'd1;
  endfunction

endpackage

// File: rtl/iob_dbus_split_wdog.sv
// Read watchdog: counts stalled cycles; done_o flags the cycle in which the count reaches TOUT_MAX.
module iob_dbus_split_wdog
  import iob_dbus_split_pkg::*;
#(
  parameter int TOUT_W = 8
) (
  input  logic clk_i,
  input  logic arst_n_i,
  input  logic cke_i,
  input  logic clr_i,
  input  logic en_i,
  output logic done_o
);

  localparam logic [TOUT_W-1:0] LAST = TOUT_W'(TOUT_MAX(TOUT_W) - 1);

  logic [TOUT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + TOUT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      cnt_q <= '0;
    end else if (cke_i) begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = en_i & ~clr_i & (cnt_q == LAST);

endmodule

// File: rtl/iob_dbus_split.sv
// Routes one IOb master onto N_SLAVES ports by top address bits, tracking the single pending read.
// A stalled read or an unmapped address ends in an all-ones rvalid plus an err_o pulse.
module iob_dbus_split
  import iob_dbus_split_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int N_SLAVES = 4,
  parameter int SEL_W    = 2,
  parameter int TOUT_W   = 8
) (
  input  logic                         clk_i,
  input  logic                         arst_n_i,
  input  logic                         cke_i,
  input  logic                         m_avalid_i,
  input  logic [ADDR_W-1:0]            m_addr_i,
  input  logic [DATA_W-1:0]            m_wdata_i,
  input  logic [DATA_W/8-1:0]          m_wstrb_i,
  output logic [DATA_W-1:0]            m_rdata_o,
  output logic                         m_rvalid_o,
  output logic                         m_ready_o,
  output logic [N_SLAVES-1:0]          s_avalid_o,
  output logic [ADDR_W-1:0]            s_addr_o,
  output logic [DATA_W-1:0]            s_wdata_o,
  output logic [DATA_W/8-1:0]          s_wstrb_o,
  input  logic [N_SLAVES*DATA_W-1:0]   s_rdata_i,
  input  logic [N_SLAVES-1:0]          s_rvalid_i,
  input  logic [N_SLAVES-1:0]          s_ready_i,
  output logic                         err_o
);

  state_e               state_q, state_d;
  logic [SEL_W-1:0]     pend_sel_q, pend_sel_d;
  logic                 err_q, err_d;
  logic [SEL_W-1:0]     sel;
  logic [N_SLAVES-1:0]  sel_hit, pend_hit;
  logic [DATA_W-1:0]    pend_rdata;
  logic                 in_range, is_rd, accept;
  logic                 wd_clr, wd_en, wd_done;

  assign s_addr_o  = m_addr_i;
  assign s_wdata_o = m_wdata_i;
  assign s_wstrb_o = m_wstrb_i;

  assign sel      = m_addr_i[ADDR_W-1 -: SEL_W];
  assign is_rd    = (m_wstrb_i == '0);
  assign in_range = |sel_hit;
  assign accept   = m_avalid_i & m_ready_o;

  // One-hot decode of the live and the pending slave; no hit means unmapped.
  always_comb begin
    sel_hit    = '0;
    pend_hit   = '0;
    pend_rdata = '0;
    for (int i = 0; i < N_SLAVES; i++) begin
      sel_hit[i]  = (sel == SEL_W'(i));
      pend_hit[i] = (pend_sel_q == SEL_W'(i));
      if (pend_sel_q == SEL_W'(i)) begin
        pend_rdata = s_rdata_i[i*DATA_W +: DATA_W];
      end
    end
  end

  iob_dbus_split_wdog #(
    .TOUT_W (TOUT_W)
  ) u_wdog (
    .clk_i    (clk_i),
    .arst_n_i (arst_n_i),
    .cke_i    (cke_i),
    .clr_i    (wd_clr),
    .en_i     (wd_en),
    .done_o   (wd_done)
  );

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q    <= ST_IDLE;
      pend_sel_q <= '0;
      err_q      <= 1'b0;
    end else if (cke_i) begin
      state_q    <= state_d;
      pend_sel_q <= pend_sel_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pend_sel_d = pend_sel_q;
    err_d      = 1'b0;
    wd_clr     = 1'b0;
    wd_en      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (is_rd && in_range) begin
            pend_sel_d = sel;
            wd_clr     = 1'b1;
            state_d    = ST_WAIT_RD;
          end else if (is_rd) begin
            state_d = ST_ERR_RD;
          end else if (!in_range) begin
            err_d = 1'b1;
          end
        end
      end
      ST_WAIT_RD: begin
        // A slave answer in the limit cycle takes priority over the timeout.
        if (m_rvalid_o) begin
          state_d = ST_IDLE;
        end else begin
          wd_en = 1'b1;
          if (wd_done) begin
            state_d = ST_ERR_RD;
          end
        end
      end
      ST_ERR_RD: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    s_avalid_o = '0;
    m_ready_o  = 1'b0;
    m_rvalid_o = 1'b0;
    m_rdata_o  = '0;
    err_o      = err_q;
    case (state_q)
      ST_IDLE: begin
        if (in_range) begin
          for (int i = 0; i < N_SLAVES; i++) begin
            s_avalid_o[i] = m_avalid_i & sel_hit[i];
          end
          m_ready_o = |(s_ready_i & sel_hit);
        end else begin
          m_ready_o = 1'b1;
        end
      end
      ST_WAIT_RD: begin
        m_rvalid_o = |(s_rvalid_i & pend_hit);
        m_rdata_o  = pend_rdata;
      end
      ST_ERR_RD: begin
        m_rvalid_o = 1'b1;
        m_rdata_o  = ERR_RDATA[DATA_W-1:0];
        err_o      = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_iob_dbus_split.sv
// Directed and randomized transactions against a per-transaction model of the splitter's timing rules.
module tb_iob_dbus_split;

  localparam int NS   = 3;
  localparam int DW   = 32;
  localparam int AW   = 32;
  localparam int TOUT = 8;

  logic              clk_i = 1'b0;
  logic              arst_n_i, cke_i;
  logic              m_avalid_i;
  logic [AW-1:0]     m_addr_i;
  logic [DW-1:0]     m_wdata_i;
  logic [DW/8-1:0]   m_wstrb_i;
  logic [DW-1:0]     m_rdata_o;
  logic              m_rvalid_o, m_ready_o;
  logic [NS-1:0]     s_avalid_o;
  logic [AW-1:0]     s_addr_o;
  logic [DW-1:0]     s_wdata_o;
  logic [DW/8-1:0]   s_wstrb_o;
  logic [NS*DW-1:0]  s_rdata_i;
  logic [NS-1:0]     s_rvalid_i, s_ready_i;
  logic              err_o;

  int n_cmp = 0;
  int n_bad = 0;

  iob_dbus_split #(
    .ADDR_W(AW), .DATA_W(DW), .N_SLAVES(NS), .SEL_W(2), .TOUT_W(TOUT)
  ) dut (
    .clk_i(clk_i), .arst_n_i(arst_n_i), .cke_i(cke_i),
    .m_avalid_i(m_avalid_i), .m_addr_i(m_addr_i), .m_wdata_i(m_wdata_i), .m_wstrb_i(m_wstrb_i),
    .m_rdata_o(m_rdata_o), .m_rvalid_o(m_rvalid_o), .m_ready_o(m_ready_o),
    .s_avalid_o(s_avalid_o), .s_addr_o(s_addr_o), .s_wdata_o(s_wdata_o), .s_wstrb_o(s_wstrb_o),
    .s_rdata_i(s_rdata_i), .s_rvalid_i(s_rvalid_i), .s_ready_i(s_ready_i),
    .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Request phase: hold the request until the addressed slave (or the error path) accepts it.
  task automatic issue(input int sel, input bit wr, input int rdy_dly);
    bit inr = (sel < NS);
    int dly = inr ? rdy_dly : 0;
    m_addr_i   = {2'(sel), 30'($urandom)};
    m_wdata_i  = $urandom;
    m_wstrb_i  = wr ? 4'($urandom_range(1, 15)) : 4'h0;
    m_avalid_i = 1'b1;
    for (int k = 0; k <= dly; k++) begin
      s_ready_i = 3'($urandom);
      if (inr) s_ready_i[sel] = (k >= dly);
      #1;
      chk("req_avalid", 64'(s_avalid_o), inr ? (64'd1 << sel) : 64'd0);
      chk("req_ready", 64'(m_ready_o), 64'(!inr || k >= dly));
      chk("req_rvalid", 64'(m_rvalid_o), 64'd0);
      if (k == 0) begin
        chk("pass_addr", 64'(s_addr_o), 64'(m_addr_i));
        chk("pass_wstrb", 64'(s_wstrb_o), 64'(m_wstrb_i));
      end
      tick();
    end
    m_avalid_i = 1'b0;
    s_ready_i  = '0;
  endtask

  // Response phase. rv_dly = 0 means the slave never answers; gap = cke-low cycles while waiting.
  task automatic respond(input int sel, input bit wr, input int rv_dly, input int gap,
                         input logic [31:0] dat);
    bit inr = (sel < NS);
    int exp_rv, exp_err, last;
    bit pending;
    if (wr) begin
      exp_rv = 0; exp_err = inr ? 0 : 1;
    end else if (!inr) begin
      exp_rv = 1; exp_err = 1;
    end else if (rv_dly > 0) begin
      exp_rv = rv_dly; exp_err = 0;
    end else begin
      exp_rv = (1 << TOUT) + gap; exp_err = exp_rv;
    end
    last = ((exp_rv > 0) ? exp_rv : 1) + 1;
    for (int j = 1; j <= last; j++) begin
      pending    = !wr && inr && (j <= exp_rv);
      s_rdata_i  = {$urandom, $urandom, $urandom};
      s_rvalid_i = (j < last) ? 3'($urandom) : 3'b111;
      if (inr && j < last) s_rvalid_i[sel] = (!wr && rv_dly > 0 && j == rv_dly);
      if (inr && !wr && rv_dly > 0 && j == rv_dly) s_rdata_i[sel*DW +: DW] = dat;
      cke_i      = !(j >= 5 && j < 5 + gap);
      m_avalid_i = pending ? 1'($urandom) : 1'b0;
      m_addr_i   = {2'($urandom_range(0, 2)), 30'($urandom)};
      m_wstrb_i  = '0;
      #1;
      chk("rsp_rvalid", 64'(m_rvalid_o), 64'(j == exp_rv));
      chk("rsp_err", 64'(err_o), 64'(j == exp_err));
      if (j == exp_rv)
        chk("rsp_rdata", 64'(m_rdata_o), (inr && rv_dly > 0) ? 64'(dat) : 64'hFFFF_FFFF);
      if (pending) begin
        chk("stall_ready", 64'(m_ready_o), 64'd0);
        chk("stall_avalid", 64'(s_avalid_o), 64'd0);
      end
      tick();
    end
    s_rvalid_i = '0;
    m_avalid_i = 1'b0;
    cke_i      = 1'b1;
  endtask

  initial begin
    arst_n_i   = 1'b0;
    cke_i      = 1'b1;
    m_avalid_i = 1'b0;
    m_addr_i   = '0;
    m_wdata_i  = '0;
    m_wstrb_i  = '0;
    s_rdata_i  = '0;
    s_rvalid_i = '0;
    s_ready_i  = '0;
    #3;
    chk("rst_rvalid", 64'(m_rvalid_o), 64'd0);
    chk("rst_ready", 64'(m_ready_o), 64'd0);
    chk("rst_avalid", 64'(s_avalid_o), 64'd0);
    chk("rst_rdata", 64'(m_rdata_o), 64'd0);
    chk("rst_err", 64'(err_o), 64'd0);
    tick();
    tick();
    arst_n_i = 1'b1;
    tick();

    // Read routed to slave 1 with immediate ready and a one-cycle response.
    issue(1, 1'b0, 0);
    respond(1, 1'b0, 1, 0, 32'h1234_5678);

    // Write to slave 2 held off for three cycles.
    issue(2, 1'b1, 3);
    respond(2, 1'b1, 0, 0, 32'h0);

    // Dead slave 0: watchdog terminates the read, late answer ignored.
    issue(0, 1'b0, 0);
    respond(0, 1'b0, 0, 0, 32'h0);

    // Unmapped read and write (slot 3 with three slaves).
    issue(3, 1'b0, 2);
    respond(3, 1'b0, 0, 0, 32'h0);
    issue(3, 1'b1, 0);
    respond(3, 1'b1, 0, 0, 32'h0);

    // Timeout pushed out by ten cycles of clock-enable low.
    issue(0, 1'b0, 1);
    respond(0, 1'b0, 0, 10, 32'h0);

    // Reset during a pending read abandons it.
    issue(1, 1'b0, 0);
    tick();
    tick();
    arst_n_i = 1'b0;
    #1;
    chk("mid_rst_rvalid", 64'(m_rvalid_o), 64'd0);
    chk("mid_rst_ready", 64'(m_ready_o), 64'd0);
    chk("mid_rst_avalid", 64'(s_avalid_o), 64'd0);
    chk("mid_rst_err", 64'(err_o), 64'd0);
    tick();
    arst_n_i = 1'b1;
    tick();
    s_rvalid_i[1] = 1'b1;
    s_rdata_i     = {$urandom, $urandom, $urandom};
    #1;
    chk("post_rst_stray", 64'(m_rvalid_o), 64'd0);
    tick();
    s_rvalid_i = '0;

    for (int t = 0; t < 40; t++) begin
      int  sel = $urandom_range(0, 3);
      bit  wr  = 1'($urandom);
      int  rd  = $urandom_range(0, 3);
      int  rv  = $urandom_range(1, 4);
      logic [31:0] d = $urandom;
      issue(sel, wr, rd);
      respond(sel, wr, rv, 0, d);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
